// File: rtl/rf_scoreboard_arb.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard_arb
// Description : Write-port arbiter and hazard scoreboard for a 32-entry
//               register file. Grants one of two writeback sources (ALU,
//               memory) per cycle, alternating on conflict. Tracks busy
//               destination registers and stalls issue on RAW/WAW hazards.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   issue_valid/_r0/_r1/_rd  issue-stage instruction (sources, destination)
//   issue_ready              no hazard; accepted when valid && ready
//   wa_valid/_rd/_data       ALU writeback request
//   wm_valid/_rd/_data       memory writeback request
//   wa_ready, wm_ready       request granted this cycle
//   rf_rd, rf_data           register-file write port (ZERO_REG/0 when idle)
//   pending                  number of outstanding busy registers
//   idle                     pending == 0
//   err                      sticky: writeback to a non-busy, non-zero reg
// ============================================================================
module rf_scoreboard_arb #(
    parameter int WIDTH    = 16,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [4:0]       issue_r0,
    input  logic [4:0]       issue_r1,
    input  logic [4:0]       issue_rd,
    output logic             issue_ready,
    input  logic             wa_valid,
    input  logic [4:0]       wa_rd,
    input  logic [WIDTH-1:0] wa_data,
    output logic             wa_ready,
    input  logic             wm_valid,
    input  logic [4:0]       wm_rd,
    input  logic [WIDTH-1:0] wm_data,
    output logic             wm_ready,
    output logic [4:0]       rf_rd,
    output logic [WIDTH-1:0] rf_data,
    output logic [5:0]       pending,
    output logic             idle,
    output logic             err
);

    localparam logic [4:0] c_zero_idx = ZERO_REG[4:0];

    logic [31:0] busy_q, busy_d;
    logic        last_grant_q, last_grant_d;   // 0 = ALU, 1 = MEM
    logic [5:0]  pending_q, pending_d;
    logic        err_q, err_d;

    logic [31:0] w_busy;
    logic        w_grant_a, w_grant_m, w_grant;
    logic [4:0]  w_grant_rd;
    logic        w_issue_acc, w_set, w_clr, w_inc, w_dec;

    // The zero register is never reported busy, whatever the flop holds.
    assign w_busy = busy_q & ~(32'd1 << c_zero_idx);

    // Registered busy only: a write granted this cycle does not unblock issue
    // until the next cycle.
    assign issue_ready = !w_busy[issue_r0] && !w_busy[issue_r1] && !w_busy[issue_rd];
    assign w_issue_acc = issue_valid && issue_ready;

    // On conflict the source that did not win last time is granted.
    assign w_grant_a  = wa_valid && (!wm_valid || last_grant_q);
    assign w_grant_m  = wm_valid && (!wa_valid || !last_grant_q);
    assign w_grant    = w_grant_a || w_grant_m;
    assign w_grant_rd = w_grant_a ? wa_rd : wm_rd;

    assign wa_ready = w_grant_a;
    assign wm_ready = w_grant_m;
    assign rf_rd    = w_grant ? w_grant_rd : c_zero_idx;
    assign rf_data  = w_grant_a ? wa_data : (w_grant_m ? wm_data : '0);

    assign w_set = w_issue_acc && (issue_rd != c_zero_idx);
    assign w_clr = w_grant && (w_grant_rd != c_zero_idx);

    // pending mirrors the population count of busy. A set of an already-busy
    // bit, or a clear that is overridden by a same-index set, does not count.
    assign w_inc = w_set && !w_busy[issue_rd];
    assign w_dec = w_clr && w_busy[w_grant_rd] && !(w_set && (issue_rd == w_grant_rd));

    always_comb begin
        busy_d = busy_q;
        if (w_clr) begin
            busy_d[w_grant_rd] = 1'b0;
        end
        // Set after clear so a same-index set wins.
        if (w_set) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[c_zero_idx] = 1'b0;
    end

    always_comb begin
        pending_d = pending_q;
        if (w_inc && !w_dec) begin
            pending_d = pending_q + 6'd1;
        end else if (w_dec && !w_inc) begin
            pending_d = pending_q - 6'd1;
        end
    end

    // A write to a register nobody is waiting on is still performed, but
    // flagged.
    assign err_d        = err_q || (w_clr && !w_busy[w_grant_rd]);
    assign last_grant_d = (wa_valid && wm_valid) ? w_grant_m : last_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            last_grant_q <= 1'b1;
            pending_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            last_grant_q <= last_grant_d;
            pending_q    <= pending_d;
            err_q        <= err_d;
        end
    end

    assign pending = pending_q;
    assign idle    = (pending_q == 6'd0);
    assign err     = err_q;

endmodule
`default_nettype wire
